// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
   parameter int BAUD_RATE   = 115200,
   parameter int CLOCK_SPEED = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int TICKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
   localparam int HALF_BIT      = TICKS_PER_BIT / 2;
   localparam int CW            = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   logic          sync1;
   logic          rx_s;
   state_t        state;
   state_t        state_next;
   logic [CW-1:0] tick_cnt;
   logic [CW-1:0] tick_next;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_next;
   logic [7:0]    shift_reg;
   logic [7:0]    shift_next;
   logic          deliver;
   logic          ferr_next;

   // Input synchronizer, preset high so reset never fakes a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rx_s  <= sync1;
      end
   end

   // Receive state, bit timing and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         tick_cnt  <= {CW{1'b0}};
         bit_idx   <= 3'd0;
         shift_reg <= 8'h00;
      end else begin
         state     <= state_next;
         tick_cnt  <= tick_next;
         bit_idx   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   // Next-state logic: tick counter restarts on every state entry and sample.
   always_comb begin
      state_next = state;
      tick_next  = tick_cnt + {{(CW-1){1'b0}}, 1'b1};
      bit_next   = bit_idx;
      shift_next = shift_reg;
      deliver    = 1'b0;
      ferr_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            tick_next = {CW{1'b0}};
            if (!rx_s) begin
               state_next = ST_START;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_cnt == HALF_LAST) begin
               tick_next = {CW{1'b0}};
               if (!rx_s) begin
                  state_next = ST_DATA;
                  bit_next   = 3'd0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               state_next = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
               tick_next           = {CW{1'b0}};
               shift_next[bit_idx] = rx_s;
               bit_next            = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_next = ST_STOP;
               end else begin
                  state_next = ST_DATA;
               end
            end else begin
               state_next = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
               tick_next = {CW{1'b0}};
               if (rx_s) begin
                  deliver    = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = ST_BRK;
               end
            end else begin
               state_next = ST_STOP;
            end
         end
         ST_BRK: begin
            // A held-low line stays here instead of producing 0x00 frames.
            tick_next = {CW{1'b0}};
            if (rx_s) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_BRK;
            end
         end
         default: begin
            state_next = ST_IDLE;
            tick_next  = {CW{1'b0}};
         end
      endcase
   end

   // Holding register, handshake and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
         rx_busy     <= 1'b0;
      end else begin
         frame_error <= ferr_next;
         overrun     <= deliver & rx_valid & ~rx_ready;
         rx_busy     <= (state_next != ST_IDLE);
         if (deliver && (!rx_valid || rx_ready)) begin
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural line driver pushes expected bytes,
// a negedge monitor pops them on each handshake and counts status pulses.
module tb_uart_rx;

   localparam int CLOCK_SPEED = 1_600_000;
   localparam int BAUD_RATE   = 100_000;
   localparam int T           = CLOCK_SPEED / BAUD_RATE;
   localparam int H           = T / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun;
   logic       rx_busy;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         exp_fe = 0;
   int         exp_ov = 0;
   int         cyc = 0;
   int         rise_cyc = -1;
   bit         prev_valid = 1'b0;

   uart_rx #(.BAUD_RATE(BAUD_RATE), .CLOCK_SPEED(CLOCK_SPEED)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_error(frame_error), .overrun(overrun), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // Behavioural 8N1 transmitter: start, 8 data bits LSB first, stop.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      serial_in = 1'b0;
      tick(T);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         tick(T);
      end
      serial_in = stop_bit;
      tick(T);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
      check("bytes_outstanding", exp_q.size(), 0);
      check("frame_error_count", fe_cnt, exp_fe);
      check("overrun_count", ov_cnt, exp_ov);
   endtask

   // Monitor: scoreboard pop on each accepted byte, pulse counting.
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_valid = 1'b0;
         end else begin
            if (rx_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
            prev_valid = (rx_valid === 1'b1);
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_byte: got %02h, expected none", rx_data);
               end else begin
                  check("rx_data", rx_data, exp_q.pop_front());
               end
            end
            if (frame_error === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      logic       err;
      int         start_cyc;

      serial_in = 1'b1;
      rx_ready  = 1'b1;
      rst       = 1'b1;
      tick(3);
      rst = 1'b0;
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_frame_error", frame_error, 0);
      check("reset_overrun", overrun, 0);
      check("reset_rx_busy", rx_busy, 0);
      tick(T);

      // Basic byte and exact start-edge-to-valid latency (2 sync flops included).
      start_cyc = cyc;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      check("valid_latency", rise_cyc - start_cyc, 3 + H + 9 * T);
      drain();

      // Short low glitch must not start a frame.
      serial_in = 1'b0;
      tick(H / 2);
      serial_in = 1'b1;
      tick(2 * T);
      check("glitch_busy", rx_busy, 0);
      check("glitch_valid", rx_valid, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      drain();

      // Framing error followed by a long break.
      send_frame(8'h81, 1'b0);
      exp_fe++;
      tick(12 * T);
      check("break_busy", rx_busy, 1);
      check("break_valid", rx_valid, 0);
      check("break_single_error", fe_cnt, exp_fe);
      serial_in = 1'b1;
      tick(4);
      check("break_exit_busy", rx_busy, 0);
      exp_q.push_back(8'h42);
      send_frame(8'h42, 1'b1);
      drain();

      // Overrun: second byte dropped while the first is unconsumed.
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      exp_ov++;
      tick(2);
      check("overrun_valid_held", rx_valid, 1);
      check("overrun_data_kept", rx_data, 8'h11);
      check("overrun_pulse", ov_cnt, exp_ov);
      rx_ready = 1'b1;
      tick(1);
      check("overrun_valid_drop", rx_valid, 0);
      drain();

      // Reset in the middle of data bit 4 abandons the frame.
      b = 8'h5A;
      serial_in = 1'b0;
      tick(T);
      for (int i = 0; i < 4; i++) begin
         serial_in = b[i];
         tick(T);
      end
      serial_in = b[4];
      tick(H);
      check("midframe_busy", rx_busy, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      serial_in = 1'b1;
      check("midreset_rx_valid", rx_valid, 0);
      check("midreset_rx_data", rx_data, 0);
      check("midreset_rx_busy", rx_busy, 0);
      tick(12 * T);
      exp_q.push_back(8'h96);
      send_frame(8'h96, 1'b1);
      drain();

      // Random traffic: gaps (including back-to-back), glitches, framing errors.
      for (int n = 0; n < 40; n++) begin
         tick($urandom_range(0, T));
         if ($urandom_range(0, 5) == 0) begin
            serial_in = 1'b0;
            tick($urandom_range(1, H - 2));
            serial_in = 1'b1;
            tick(H + 4);
         end
         b   = 8'($urandom);
         err = ($urandom_range(0, 7) == 0);
         if (err) exp_fe++;
         else exp_q.push_back(b);
         send_frame(b, ~err);
         if (err) begin
            tick($urandom_range(0, 3 * T));
            serial_in = 1'b1;
            tick(3);
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the downstream counterpart of the UART transmitter. Consumes the 8N1 serial stream (1 start bit, 8 data bits LSB first, 1 stop bit, idle high) that the transmitter produces.
- Recovers bytes by mid-bit sampling.
- Presents each byte on a valid/ready handshake to the core or a receive FIFO.
- Reports framing errors and overruns.

Parameters:
- BAUD_RATE, 115200, serial bit rate.
- CLOCK_SPEED, 100_000_000, clk frequency in Hz.
- TICKS_PER_BIT, CLOCK_SPEED / BAUD_RATE (derived, 868 at defaults), clk cycles per bit.
- HALF_BIT, TICKS_PER_BIT / 2 (derived, 434 at defaults), start-bit verify point.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_valid is high.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a rising clk edge.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst). All logic is on posedge clk; no derived clocks.
- Reset values:
  - rx_data = 0, rx_valid = 0, frame_error = 0, overrun = 0, rx_busy = 0.
  - Synchronizer flops = 1; state = IDLE; counters = 0.
- Reset mid-frame abandons the frame with no output pulse. After reset, the receiver re-arms only on a new falling edge: it waits in IDLE for line low after first seeing high (synchronizer preset to 1 guarantees this).
- Input synchronizer: serial_in passes through 2 flops; rx_s is the second flop. All decisions use rx_s only.
- Tick counter: tick_cnt, wide enough for TICKS_PER_BIT-1. Cleared on every state entry and after each sample.
- State machine:
  - IDLE: if rx_s == 0, go to START, tick_cnt = 0.
  - START: increment tick_cnt. When tick_cnt == HALF_BIT-1, sample rx_s. If 0, go to DATA with bit_idx = 0 and tick_cnt = 0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: when tick_cnt == TICKS_PER_BIT-1, shift rx_s into shift_reg[bit_idx] (LSB first), bit_idx++, tick_cnt = 0. After the bit_idx == 7 sample, go to STOP.
  - STOP: when tick_cnt == TICKS_PER_BIT-1, sample rx_s.
    - If 1: deliver shift_reg (see holding register) and go to IDLE.
    - If 0: pulse frame_error for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. Prevents a held-low line (break) from being read as repeated 0x00 frames.
- Timing: let t0 be the cycle IDLE first sees rx_s == 0.
  - Start verified at t0+HALF_BIT.
  - Data bit i sampled at t0+HALF_BIT+(i+1)*TICKS_PER_BIT.
  - Stop sampled at t0+HALF_BIT+9*TICKS_PER_BIT.
  - rx_valid / frame_error assert the following cycle.
- Holding register and handshake:
  - On delivery with rx_valid == 0: rx_data <= byte, rx_valid <= 1.
  - Delivery while rx_valid == 1 and rx_ready == 1 in the same cycle: old byte is consumed, rx_data <= new byte, rx_valid stays 1, no overrun.
  - Delivery while rx_valid == 1 and rx_ready == 0: new byte is dropped, rx_data unchanged, overrun pulses for 1 cycle.
  - rx_valid && rx_ready with no delivery: rx_valid <= 0 next cycle; rx_data holds its value.
  - rx_ready is ignored while rx_valid == 0.
- Back-to-back frames: the receiver returns to IDLE half a bit into the stop bit. A start edge immediately following the stop bit must be caught.

Test Plan:
- Defaults; send 0x55 at 868 cycles/bit, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x55, exactly HALF_BIT+9*868+1 cycles after t0; frame_error=overrun=0.
- Loopback: uart_tx output drives serial_in, sending 0xA3, 0x00, 0xFF back-to-back, rx_ready=1 -> three valid bytes in order 0xA3, 0x00, 0xFF; no errors.
- Glitch: drive serial_in low for 200 cycles, then high -> returns to IDLE, no rx_valid and no error; a following 0x3C is received correctly.
- Framing: send 0x81 with stop bit low, line held low 3000 cycles, then high -> single frame_error pulse, rx_valid stays 0, rx_busy high until the line goes high; next 0x42 is received.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 with rx_valid held; overrun pulses once at 0x22's stop sample; raise rx_ready -> rx_valid drops next cycle.
- Reset mid-frame: assert rst during DATA bit 4 of 0x5A for 1 cycle -> all outputs at reset values, no valid or error for that frame; next 0x96 is received correctly.
